ifetch_6502: RTL

IFETCH_6502 -- requirements
Module: ifetch_6502

---
 rtl/ooo6502_pkg.sv | 20 ++
 rtl/op_len_6502.sv | 80 ++++++++
 rtl/ifetch_6502.sv | 95 +++++++++
 3 files changed

// File: rtl/ooo6502_pkg.sv
// ooo6502_pkg: shared 6502 fetch types, addressing modes and instruction-length constants
package ooo6502_pkg;

    localparam int PC_W = 16;

    localparam logic [1:0] LEN1 = 2'd1;
    localparam logic [1:0] LEN2 = 2'd2;
    localparam logic [1:0] LEN3 = 2'd3;

    typedef enum logic [3:0] {
        AM_IMP, AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_IZX,
        AM_IZY, AM_REL, AM_ABS, AM_ABX, AM_ABY, AM_IND
    } am_e;

    function automatic logic [1:0] am_len(input am_e m);
        return (m == AM_IMP) ? LEN1 :
               (m == AM_ABS || m == AM_ABX || m == AM_ABY || m == AM_IND) ? LEN3 : LEN2;
    endfunction

endpackage

// File: rtl/op_len_6502.sv
// op_len_6502: combinational 6502 opcode to length / undocumented-opcode decoder
// IFETCH_ILLEGAL_TRAP_EN: when defined, undocumented NMOS opcodes decode as 1 byte and flag illegal.
module op_len_6502
    import ooo6502_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len,
    output logic       illegal
);

    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] c;
    am_e        mode;
    logic       idx_y;

    assign {a, b, c} = opcode;
    // STX/LDX and their undocumented neighbours in rows 8x/9x, Ax/Bx index with Y
    assign idx_y = (a == 3'd4) || (a == 3'd5);

    // addressing mode from the aaabbbcc column layout of the opcode map
    always_comb begin
        mode = AM_IMP;
        case (c)
            2'b00:
                case (b)
                    3'd0:    mode = (a == 3'd1) ? AM_ABS : a[2] ? AM_IMM : AM_IMP;
                    3'd1:    mode = AM_ZP;
                    3'd3:    mode = (a == 3'd3) ? AM_IND : AM_ABS;
                    3'd4:    mode = AM_REL;
                    3'd5:    mode = AM_ZPX;
                    3'd7:    mode = AM_ABX;
                    default: mode = AM_IMP;
                endcase
            2'b10:
                case (b)
                    3'd0:    mode = AM_IMM;
                    3'd1:    mode = AM_ZP;
                    3'd3:    mode = AM_ABS;
                    3'd5:    mode = idx_y ? AM_ZPY : AM_ZPX;
                    3'd7:    mode = idx_y ? AM_ABY : AM_ABX;
                    default: mode = AM_IMP;
                endcase
            default:
                case (b)
                    3'd0:    mode = AM_IZX;
                    3'd1:    mode = AM_ZP;
                    3'd2:    mode = AM_IMM;
                    3'd3:    mode = AM_ABS;
                    3'd4:    mode = AM_IZY;
                    3'd5:    mode = (c[1] && idx_y) ? AM_ZPY : AM_ZPX;
                    3'd6:    mode = AM_ABY;
                    default: mode = (c[1] && idx_y) ? AM_ABY : AM_ABX;
                endcase
        endcase
    end

`ifdef IFETCH_ILLEGAL_TRAP_EN
    logic undoc;

    // holes in the documented NMOS opcode map
    assign undoc = (c == 2'b11) ||
                   (c == 2'b01 && b == 3'd2 && a == 3'd4) ||
                   (c == 2'b00 && ((b == 3'd0 && a == 3'd4) ||
                                   (b == 3'd1 && (a == 3'd0 || a == 3'd2 || a == 3'd3)) ||
                                   (b == 3'd3 && a == 3'd0) ||
                                   (b == 3'd5 && !idx_y) ||
                                   (b == 3'd7 && a != 3'd5))) ||
                   (c == 2'b10 && ((b == 3'd0 && a != 3'd5) ||
                                   (b == 3'd4) ||
                                   (b == 3'd6 && !idx_y) ||
                                   (b == 3'd7 && a == 3'd4)));
    assign illegal = undoc;
    assign len     = undoc ? LEN1 : am_len(mode);
`else
    assign illegal = 1'b0;
    assign len     = am_len(mode);
`endif

endmodule

// File: rtl/ifetch_6502.sv
// ifetch_6502: 6502 instruction fetch unit with byte queue and length decode
// IFETCH_ILLEGAL_TRAP_EN: when defined, undocumented opcodes are reported as 1-byte illegal instructions.
module ifetch_6502
    import ooo6502_pkg::*;
#(
    parameter int              QDEPTH   = 8,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] addr_o,
    input  logic [7:0]      din_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [7:0]      inst_opcode_o,
    output logic [7:0]      inst_op1_o,
    output logic [7:0]      inst_op2_o,
    output logic [1:0]      inst_len_o,
    output logic [PC_W-1:0] inst_pc_o,
    output logic            inst_illegal_o
);

    localparam int AW = $clog2(QDEPTH);

    logic [7:0]      q [QDEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] head_pc;
    logic            in_flight;
    logic            kill;
    logic            issue;
    logic            push;
    logic            pop;
    logic [1:0]      len;
    logic            illegal;

    op_len_6502 u_len (
        .opcode  (q[rd_ptr]),
        .len     (len),
        .illegal (illegal)
    );

    // the in-flight byte reserves a slot so the queue can never overflow
    assign issue = !redirect_i && ((count + (AW+1)'(in_flight)) < (AW+1)'(QDEPTH));
    assign push  = in_flight && !kill && !redirect_i;
    assign pop   = inst_valid_o && inst_ready_i && !redirect_i;

    assign addr_o         = fetch_pc;
    assign inst_valid_o   = count >= (AW+1)'(len);
    assign inst_opcode_o  = q[rd_ptr];
    assign inst_op1_o     = (len != LEN1) ? q[rd_ptr + AW'(1)] : 8'h00;
    assign inst_op2_o     = (len == LEN3) ? q[rd_ptr + AW'(2)] : 8'h00;
    assign inst_len_o     = len;
    assign inst_pc_o      = head_pc;
    assign inst_illegal_o = illegal && inst_valid_o;

    // queue storage carries no reset; count alone says what is valid
    always_ff @(posedge clk)
        if (push) q[wr_ptr] <= din_i;

    // fetch pointer, queue bookkeeping, and redirect flush
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            fetch_pc  <= RESET_PC;
            head_pc   <= RESET_PC;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            in_flight <= 1'b0;
            kill      <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc  <= redirect_pc_i;
            head_pc   <= redirect_pc_i;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            in_flight <= 1'b0;
            kill      <= in_flight;
        end else begin
            fetch_pc  <= fetch_pc + PC_W'(issue);
            in_flight <= issue;
            kill      <= 1'b0;
            count     <= count + (AW+1)'(push) - (pop ? (AW+1)'(len) : '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(len);
                head_pc <= head_pc + PC_W'(len);
            end
        end

endmodule
